approx_mul_err_sweep: RTL and testbench

- Sequential characterisation engine that sits directly upstream and downstream of a combinational GenMul-generated approximate multiplier.
- It drives every operand pair onto the multiplier inputs, consumes the approximate product, and compares it against an internally computed exact product.
- It accumulates error statistics (SSE, worst-case error, error count) used for area/MSE ranking of the multiplier variants.

---
 rtl/approx_mul_err_sweep.sv | 195 +++++++++++++++++++
 tb/tb_approx_mul_err_sweep.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_err_sweep.sv
// Error-statistics sweep engine for a combinational approximate multiplier.
// Latency: start accepted in cycle 0 -> done high in cycle 2^(2*WIDTH)+3 (2-stage error pipeline).
// Backpressure: none; start is ignored while busy, and results are held in DONE until the next start.
//
// Ports: clk/rst_n (async active-low); start pulse; op_a/op_b drive the multiplier and approx_p
// returns its product combinationally; busy/done status; sse, max_abs_err, wce_a/wce_b and
// err_count hold the statistics. With ERR_BIAS_EN defined, an extra signed err_sum output
// holds the running sum of signed errors.
module approx_mul_err_sweep #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  input  logic [2*WIDTH-1:0]   approx_p,
  output logic                 busy,
  output logic                 done,
  output logic [6*WIDTH-1:0]   sse,
  output logic [2*WIDTH-1:0]   max_abs_err,
  output logic [WIDTH-1:0]     wce_a,
  output logic [WIDTH-1:0]     wce_b,
  output logic [2*WIDTH:0]     err_count
`ifdef ERR_BIAS_EN
  ,
  output logic signed [4*WIDTH:0] err_sum
`endif
);

  localparam int PW = 2 * WIDTH;      // product / index width
  localparam int EW = PW + 1;         // signed error width
  localparam int SW = 6 * WIDTH;      // sum of squared errors width

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DRAIN, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         idx_q, idx_d;
  logic                  drain_q, drain_d;

  // stage 1: signed error of the pair currently on the multiplier
  logic                  s1_vld_q, s1_vld_d;
  logic signed [EW-1:0]  s1_err_q, s1_err_d;
  logic [WIDTH-1:0]      s1_a_q, s1_a_d;
  logic [WIDTH-1:0]      s1_b_q, s1_b_d;

  // stage 2: accumulators
  logic [SW-1:0]         sse_q, sse_d;
  logic [PW-1:0]         max_q, max_d;
  logic [WIDTH-1:0]      wce_a_q, wce_a_d;
  logic [WIDTH-1:0]      wce_b_q, wce_b_d;
  logic [EW-1:0]         cnt_q, cnt_d;
`ifdef ERR_BIAS_EN
  logic signed [4*WIDTH:0] sum_q, sum_d;
`endif

  logic                  accept;
  logic [PW-1:0]         exact_p;
  logic signed [EW-1:0]  err_now;
  logic [EW-1:0]         abs_e;
  logic [PW-1:0]         abs_cap;
  logic [2*EW-1:0]       sq;

  // idx is itself a register, so the operands leave the block registered
  assign op_a = idx_q[WIDTH-1:0];
  assign op_b = idx_q[PW-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    drain_d  = drain_q;
    accept   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        // last pair is issued this cycle; idx holds rather than wrapping
        if (idx_q == {PW{1'b1}}) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end else begin
          idx_d = idx_q + PW'(1);
        end
      end
      ST_DRAIN: begin
        // two cycles: last pair moves through stage 1, then stage 2
        if (drain_q) state_d = ST_DONE;
        else         drain_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    exact_p  = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
    err_now  = $signed({1'b0, approx_p}) - $signed({1'b0, exact_p});
    s1_vld_d = (state_q == ST_SWEEP);
    s1_err_d = err_now;
    s1_a_d   = op_a;
    s1_b_d   = op_b;
  end

  always_comb begin
    abs_e   = s1_err_q[EW-1] ? $unsigned(-s1_err_q) : $unsigned(s1_err_q);
    // magnitude above the product range saturates for storage
    abs_cap = abs_e[EW-1] ? {PW{1'b1}} : abs_e[PW-1:0];
    sq      = {{EW{1'b0}}, abs_e} * {{EW{1'b0}}, abs_e};

    sse_d   = sse_q;
    max_d   = max_q;
    wce_a_d = wce_a_q;
    wce_b_d = wce_b_q;
    cnt_d   = cnt_q;
`ifdef ERR_BIAS_EN
    sum_d   = sum_q;
`endif

    if (accept) begin
      sse_d   = '0;
      max_d   = '0;
      wce_a_d = '0;
      wce_b_d = '0;
      cnt_d   = '0;
`ifdef ERR_BIAS_EN
      sum_d   = '0;
`endif
    end else if (s1_vld_q) begin
      sse_d = sse_q + SW'(sq);
      cnt_d = cnt_q + {{PW{1'b0}}, (s1_err_q != '0)};
      // strict compare keeps the earliest pair in sweep order on ties
      if (abs_cap > max_q) begin
        max_d   = abs_cap;
        wce_a_d = s1_a_q;
        wce_b_d = s1_b_q;
      end
`ifdef ERR_BIAS_EN
      sum_d = sum_q + {{(4*WIDTH+1-EW){s1_err_q[EW-1]}}, s1_err_q};
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      drain_q  <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_err_q <= '0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      sse_q    <= '0;
      max_q    <= '0;
      wce_a_q  <= '0;
      wce_b_q  <= '0;
      cnt_q    <= '0;
`ifdef ERR_BIAS_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      s1_vld_q <= s1_vld_d;
      s1_err_q <= s1_err_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      sse_q    <= sse_d;
      max_q    <= max_d;
      wce_a_q  <= wce_a_d;
      wce_b_q  <= wce_b_d;
      cnt_q    <= cnt_d;
`ifdef ERR_BIAS_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign busy        = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign sse         = sse_q;
  assign max_abs_err = max_q;
  assign wce_a       = wce_a_q;
  assign wce_b       = wce_b_q;
  assign err_count   = cnt_q;
`ifdef ERR_BIAS_EN
  assign err_sum     = sum_q;
`endif

endmodule

// File: tb/tb_approx_mul_err_sweep.sv
// Bench for approx_mul_err_sweep with a behavioural approximate-multiplier stub.
// Each sweep pushes its expected statistics into a scoreboard queue at start;
// the entry is popped and compared when done rises.
module tb_approx_mul_err_sweep;

  localparam int W  = 4;
  localparam int PW = 2 * W;
  localparam int N  = 1 << PW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [W-1:0]      op_a, op_b;
  logic [PW-1:0]     approx_p;
  logic              busy, done;
  logic [6*W-1:0]    sse;
  logic [PW-1:0]     max_abs_err;
  logic [W-1:0]      wce_a, wce_b;
  logic [PW:0]       err_count;
`ifdef ERR_BIAS_EN
  logic signed [4*W:0] err_sum;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cur_mode = 0;

  typedef struct {
    longint sse;
    longint max;
    longint wa;
    longint wb;
    longint cnt;
    longint sum;
  } exp_t;

  exp_t sb[$];

  approx_mul_err_sweep #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b), .approx_p(approx_p),
    .busy(busy), .done(done), .sse(sse), .max_abs_err(max_abs_err),
    .wce_a(wce_a), .wce_b(wce_b), .err_count(err_count)
`ifdef ERR_BIAS_EN
    , .err_sum(err_sum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Approximate multiplier variants; all results stay within PW bits.
  function automatic int stub(input int a, input int b, input int mode);
    case (mode)
      0: return a * b;
      1: return a * b + 1;
      2: return 0;
      3: return (a == 1 && b == 1) ? 0 : a * b;
      default: return (a * b) ^ ((a * 3 + b) & 7);
    endcase
  endfunction

  always_comb approx_p = PW'(stub(int'(op_a), int'(op_b), cur_mode));

  // Reference statistics over the full sweep in op_a-inner order.
  function automatic exp_t model(input int mode);
    exp_t e;
    longint err, ae;
    e = '{sse: 0, max: 0, wa: 0, wb: 0, cnt: 0, sum: 0};
    for (int b = 0; b < (1 << W); b++) begin
      for (int a = 0; a < (1 << W); a++) begin
        err = longint'(stub(a, b, mode)) - longint'(a * b);
        ae  = (err < 0) ? -err : err;
        e.sse += err * err;
        e.sum += err;
        if (err != 0) e.cnt++;
        if (ae > e.max) begin
          e.max = ae;
          e.wa  = a;
          e.wb  = b;
        end
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_op_a"}, longint'(op_a), 0);
    chk({tag, "_op_b"}, longint'(op_b), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_sse"}, longint'(sse), 0);
    chk({tag, "_max"}, longint'(max_abs_err), 0);
    chk({tag, "_wce_a"}, longint'(wce_a), 0);
    chk({tag, "_wce_b"}, longint'(wce_b), 0);
    chk({tag, "_cnt"}, longint'(err_count), 0);
`ifdef ERR_BIAS_EN
    chk({tag, "_sum"}, longint'($signed(err_sum)), 0);
`endif
  endtask

  // Runs one sweep; a nonzero disturb_at pulses start that many cycles in.
  task automatic run_sweep(input int mode, input int disturb_at);
    int s_cyc;
    int n;
    exp_t e;
    cur_mode = mode;
    sb.push_back(model(mode));
    @(negedge clk);
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", longint'(busy), 1);
    chk("done_cleared", longint'(done), 0);
    n = 1;
    while (!done && n < N + 50) begin
      start = (n == disturb_at);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) begin
      chk("done_timeout", longint'(done), 1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk("done_latency", longint'(cyc - s_cyc), longint'(N + 3));
      chk("busy_at_done", longint'(busy), 0);
      chk("sse", longint'(sse), e.sse);
      chk("max_abs_err", longint'(max_abs_err), e.max);
      chk("wce_a", longint'(wce_a), e.wa);
      chk("wce_b", longint'(wce_b), e.wb);
      chk("err_count", longint'(err_count), e.cnt);
`ifdef ERR_BIAS_EN
      chk("err_sum", longint'($signed(err_sum)), e.sum);
`endif
      // results must hold while idle in DONE
      repeat (3) @(negedge clk);
      chk("hold_sse", longint'(sse), e.sse);
      chk("hold_done", longint'(done), 1);
    end
  endtask

  initial begin
    #1;
    check_zero("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle");

    run_sweep(0, 0);     // exact multiplier
    run_sweep(1, 0);     // constant +1 error, first pair wins tie
    run_sweep(2, 0);     // all-zero output, worst case at the last pair
    run_sweep(3, 0);     // single wrong pair
    run_sweep(4, 50);    // mixed signed errors with a start pulse mid-sweep

    // reset in the middle of a sweep, then a clean sweep
    cur_mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    repeat (2) @(negedge clk);
    check_zero("mid_rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(1, 0);
    run_sweep(4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
